// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: sequences one input feature vector through a shared,
// externally supplied LUT engine, one neuron per cycle, and collects the
// per-neuron 2-bit results into an output vector.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   s_data/s_valid/s_ready : input vector handshake (2 bits per feature)
//   lut_req/lut_neuron/lut_addr : LUT request, neuron select, 3x2-bit address
//   lut_data            : LUT result, valid LUT_LAT cycles after its request
//   m_data/m_valid/m_ready : output vector handshake (2 bits per neuron)
//   cfg_we/cfg_neuron/cfg_slot/cfg_idx : fan-in table write port
//   cfg_err             : one-cycle pulse when a table write is rejected
//   busy                : block is not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an input vector; table writes allowed
// ISSUE | one LUT request per cycle, neuron 0 .. NUM_NEURONS-1
// DRAIN | waiting for the last in-flight result to be captured
// OUT   | output vector valid and held until m_ready
module layer_seq_ctrl #(
  parameter  int NUM_FEATURES = 16,
  parameter  int NUM_NEURONS  = 8,
  parameter  int LUT_LAT      = 1,
  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int NW = (NUM_NEURONS  > 1) ? $clog2(NUM_NEURONS)  : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*NUM_FEATURES-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      lut_req,
  output logic [NW-1:0]             lut_neuron,
  output logic [5:0]                lut_addr,
  input  logic [1:0]                lut_data,
  output logic [2*NUM_NEURONS-1:0]  m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  input  logic                      cfg_we,
  input  logic [NW-1:0]             cfg_neuron,
  input  logic [1:0]                cfg_slot,
  input  logic [FW-1:0]             cfg_idx,
  output logic                      cfg_err,
  output logic                      busy
);

  localparam logic [NW:0]   NEURONS_EXT = (NW+1)'(NUM_NEURONS);
  localparam logic [NW-1:0] LAST_N      = NW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                        state_q;
  logic [NW-1:0]                 cnt_q;
  logic [2*NUM_FEATURES-1:0]     data_q;
  logic [2*NUM_NEURONS-1:0]      m_data_q;
  logic                          cfg_err_q;
  logic [LUT_LAT-1:0]            pipe_vld_q;
  logic [LUT_LAT-1:0][NW-1:0]    pipe_idx_q;
  logic [FW-1:0]                 tbl_q [NUM_NEURONS][3];

  logic                          accept;
  logic                          cfg_ok;
  logic                          cfg_wr;
  logic [31:0]                   cfg_idx_ext;
  logic [FW-1:0]                 cfg_idx_mod;
  logic                          cap_vld;
  logic [NW-1:0]                 cap_idx;

  assign s_ready    = (state_q == IDLE) & ~rst;
  assign busy       = (state_q != IDLE);
  assign m_valid    = (state_q == OUT);
  assign m_data     = m_data_q;
  assign cfg_err    = cfg_err_q;
  assign accept     = s_valid & s_ready;

  assign lut_req    = (state_q == ISSUE);
  assign lut_neuron = lut_req ? cnt_q : '0;

  // Write is only legal while idle; a write on the accept edge is still idle,
  // so the new entry is visible from the first request of that vector.
  assign cfg_ok      = (state_q == IDLE) && (cfg_slot != 2'd3) &&
                       ({1'b0, cfg_neuron} < NEURONS_EXT);
  assign cfg_wr      = cfg_we & cfg_ok;
  assign cfg_idx_ext = 32'(cfg_idx);
  assign cfg_idx_mod = FW'(cfg_idx_ext % 32'(NUM_FEATURES));

  // Oldest stage of the request delay line lines up with lut_data.
  assign cap_vld = pipe_vld_q[LUT_LAT-1];
  assign cap_idx = pipe_idx_q[LUT_LAT-1];

  for (genvar k = 0; k < 3; k++) begin : g_addr
    logic [FW-1:0] feat;
    assign feat = tbl_q[cnt_q][k];
    assign lut_addr[2*k +: 2] = lut_req ? data_q[{feat, 1'b0} +: 2] : 2'b00;
  end

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_tbl_row
    for (genvar k = 0; k < 3; k++) begin : g_tbl_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          tbl_q[n][k] <= FW'((3*n + k) % NUM_FEATURES);
        end else if (cfg_wr && (cfg_neuron == NW'(n)) && (cfg_slot == 2'(k))) begin
          tbl_q[n][k] <= cfg_idx_mod;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      m_data_q   <= '0;
      cfg_err_q  <= 1'b0;
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
    end else begin
      cfg_err_q  <= cfg_we & ~cfg_ok;
      // Shift in at the low end; the cast drops the stage falling off the top.
      pipe_vld_q <= LUT_LAT'({pipe_vld_q, lut_req});
      pipe_idx_q <= (LUT_LAT*NW)'({pipe_idx_q, cnt_q});

      if (cap_vld) begin
        m_data_q[{cap_idx, 1'b0} +: 2] <= lut_data;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= s_data;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_N) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cap_vld && (cap_idx == LAST_N)) begin
            state_q <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- NUM_FEATURES, 16, number of 2-bit input features per vector.
- NUM_NEURONS, 8, number of neurons sequenced through the shared LUT engine.
- LUT_LAT, 1, fixed cycles from lut_req to lut_data valid (1..4).
REQ-002 Derived widths: FW = clog2(NUM_FEATURES); NW = clog2(NUM_NEURONS); fan-in is fixed at 3; feature/output width is fixed at 2 bits.
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic rising-edge.
- rst, in, 1, synchronous, active-high reset.
- s_data, in, 2*NUM_FEATURES, input vector; feature f = s_data[2f+1:2f].
- s_valid, in, 1, input vector valid.
- s_ready, out, 1, block accepts input vector.
- lut_req, out, 1, LUT evaluation request.
- lut_neuron, out, NW, neuron index selecting the LUT contents.
- lut_addr, out, 6, LUT address; lut_addr[2k+1:2k] = feature at fan-in slot k (k = 0..2).
- lut_data, in, 2, LUT result, valid exactly LUT_LAT cycles after its lut_req.
- m_data, out, 2*NUM_NEURONS, output vector; neuron n = m_data[2n+1:2n].
- m_valid, out, 1, output vector valid.
- m_ready, in, 1, downstream accepts output.
- cfg_we, in, 1, fan-in table write strobe.
- cfg_neuron, in, NW, table row.
- cfg_slot, in, 2, table slot (0..2; 3 is illegal).
- cfg_idx, in, FW, feature index to store.
- cfg_err, out, 1, one-cycle pulse on a rejected write.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-004 The block SHALL hold a fan-in table of NUM_NEURONS x 3 entries, each FW bits wide.
REQ-005 FSM states SHALL be IDLE, ISSUE, DRAIN and OUT.
REQ-006 s_ready SHALL be 1 only in IDLE; the handshake is s_valid & s_ready, and s_data is latched on that edge.
REQ-007 On accept, the FSM SHALL enter ISSUE with the issue counter at 0.
REQ-008 In ISSUE the block SHALL, each cycle, assert lut_req, drive lut_neuron = counter and lut_addr from the latched vector per the table, then increment the counter; requests are issued back-to-back without gaps.
REQ-009 After issuing neuron NUM_NEURONS-1, the FSM SHALL go to DRAIN.
REQ-010 A capture pipeline SHALL track lut_req delayed by LUT_LAT; when the delayed request is set, lut_data SHALL be written into m_data slot (delayed neuron index).
REQ-011 DRAIN SHALL exit to OUT on the cycle after the last result is captured.
REQ-012 If accept occurs at the edge ending cycle 0, m_valid SHALL be first high in cycle NUM_NEURONS+LUT_LAT+1.
REQ-013 In OUT, m_valid SHALL be 1 and m_data SHALL be held stable until m_valid & m_ready; the FSM then goes to IDLE.
REQ-014 s_ready SHALL rise the cycle after the output handshake; there is no bypass, so back-to-back vectors incur exactly 1 idle cycle.
REQ-015 lut_req SHALL be 0 outside ISSUE; lut_addr and lut_neuron SHALL be 0 whenever lut_req is 0.
REQ-016 A cfg write SHALL take effect only when state = IDLE and cfg_slot != 3 and cfg_neuron < NUM_NEURONS; otherwise the table is unchanged and cfg_err pulses the next cycle.
REQ-017 A cfg_idx >= NUM_FEATURES SHALL be stored as cfg_idx mod NUM_FEATURES.
REQ-018 A cfg_we coincident with an accept SHALL be applied, and the new entry SHALL be used by that vector.
REQ-019 s_valid while busy SHALL be ignored with no side effects; lut_data arriving when no capture is pending SHALL be ignored.

Reset
REQ-020 While rst is high at a clock edge, all of the following SHALL hold next cycle: state = IDLE, s_ready = 0 during the reset cycle and 1 after, m_valid = 0, m_data = 0, lut_req = 0, cfg_err = 0, busy = 0, and the capture pipeline cleared.
REQ-021 Reset SHALL load the table with the default mapping: neuron n, slot k -> (3n+k) mod NUM_FEATURES.
REQ-022 Reset mid-operation SHALL abort the vector with no partial m_valid, and results returning after reset SHALL be discarded.

Verification
REQ-023 Defaults, LUT model = identity on lut_addr[1:0], s_data feature f = f mod 4 -> neuron n outputs (3n) mod 16 mod 4 = (3n) mod 4; m_valid first high in cycle 10 after accept at cycle 0.
REQ-024 Hold m_ready = 0 for 5 cycles in OUT -> m_data is stable and m_valid stays 1; s_ready rises 1 cycle after m_ready = 1.
REQ-025 Write cfg neuron 2, slot 1, idx 7 while idle -> neuron 2 lut_addr[3:2] = feature 7; the same write while busy -> cfg_err pulses once and the table is unchanged.
REQ-026 Assert rst during ISSUE at counter = 4 -> no m_valid, lut_req = 0 next cycle, s_ready = 1 two cycles later, and the table is back at the default mapping.
REQ-027 LUT_LAT = 3, two back-to-back vectors with m_ready = 1 -> the accept-to-accept period is NUM_NEURONS+LUT_LAT+2 = 13 cycles and both outputs are correct.
